// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the word-index width helper.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_t;

   // Bits needed to index a word array of the given depth.
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth < 32'd2) ? 32'd1 : 32'($clog2(depth));
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: builds the byte-write mask and merged store word,
// extracts and extends load data, and flags misaligned halfword/word accesses.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        sign_ext,
   input  logic [31:0] writedata,
   input  logic [31:0] stored,
   output logic [3:0]  wmask_c,
   output logic [31:0] wword_c,
   output logic [31:0] rdata_c,
   output logic        misalign_c
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;
   logic [31:0] rep_c;

   always_comb begin
      wmask_c    = 4'b0000;
      wword_c    = stored;
      rdata_c    = 32'd0;
      misalign_c = 1'b0;
      rep_c      = writedata;

      case (addr_lo)
         2'd0:    byte_c = stored[7:0];
         2'd1:    byte_c = stored[15:8];
         2'd2:    byte_c = stored[23:16];
         default: byte_c = stored[31:24];
      endcase
      half_c = addr_lo[1] ? stored[31:16] : stored[15:0];

      // Store data is replicated across lanes so the mask alone picks the target.
      case (size)
         SZ_BYTE: begin
            wmask_c = 4'b0001 << addr_lo;
            rep_c   = {4{writedata[7:0]}};
            rdata_c = {{24{sign_ext & byte_c[7]}}, byte_c};
         end
         SZ_HALF: begin
            wmask_c    = addr_lo[1] ? 4'b1100 : 4'b0011;
            rep_c      = {2{writedata[15:0]}};
            rdata_c    = {{16{sign_ext & half_c[15]}}, half_c};
            misalign_c = addr_lo[0];
         end
         SZ_WORD: begin
            wmask_c    = 4'b1111;
            rdata_c    = stored;
            misalign_c = |addr_lo;
         end
         default: begin
            wmask_c = 4'b0000;
         end
      endcase

      for (int b = 0; b < 4; b++) begin
         wword_c[8*b +: 8] = wmask_c[b] ? rep_c[8*b +: 8] : stored[8*b +: 8];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, configurable
// wait states, sized load/store on a word array, one-cycle response strobe.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic        resp_valid,
   output logic [31:0] readdata,
   output logic        addr_err,
   output logic [15:0] wr_count
);

   localparam int unsigned IW        = idx_width(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic        req_ready_d, resp_valid_d, capture_c, access_c;

   logic        cap_we, cap_sx;
   logic [31:0] cap_adr, cap_wd;
   logic [1:0]  cap_size;

   logic [31:0] mem [DEPTH_WORDS];

   logic [IW-1:0] widx_c;
   logic [31:0]   stored_c, wword_c, rdata_c;
   logic [3:0]    wmask_c;
   logic          misalign_c, range_err_c, err_c;

   assign widx_c      = cap_adr[IW+1:2];
   assign stored_c    = mem[widx_c];
   assign range_err_c = (cap_adr[31:2] >= 30'(DEPTH_WORDS));
   assign err_c       = (cap_size == SZ_ILLEGAL) | misalign_c | range_err_c;

   dmem_lane_align u_align (
      .size       (cap_size),
      .addr_lo    (cap_adr[1:0]),
      .sign_ext   (cap_sx),
      .writedata  (cap_wd),
      .stored     (stored_c),
      .wmask_c    (wmask_c),
      .wword_c    (wword_c),
      .rdata_c    (rdata_c),
      .misalign_c (misalign_c)
   );

   // Next-state and strobe decode.
   always_comb begin
      state_d      = state;
      cnt_d        = cnt;
      resp_valid_d = 1'b0;
      capture_c    = 1'b0;
      access_c     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               capture_c = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd0) state_d = ST_ACCESS;
            else             cnt_d   = cnt - 4'd1;
         end
         ST_ACCESS: begin
            access_c     = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= 4'd0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         readdata   <= 32'd0;
         addr_err   <= 1'b0;
         wr_count   <= 16'd0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         if (access_c) begin
            addr_err <= err_c;
            readdata <= (err_c || cap_we) ? 32'd0 : rdata_c;
            if (cap_we && !err_c && (wr_count != 16'hFFFF)) wr_count <= wr_count + 16'd1;
         end
      end
   end

   // Request capture; datapath only, meaningful once a request is accepted.
   always_ff @(posedge clk) begin
      if (capture_c) begin
         cap_we   <= memwrite;
         cap_adr  <= dataadr;
         cap_wd   <= writedata;
         cap_size <= size;
         cap_sx   <= sign_ext;
      end
   end

   // Array has no reset; a store coinciding with rst is dropped.
   always_ff @(posedge clk) begin
      if (access_c && cap_we && !err_c && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask_c[b]) mem[widx_c][8*b +: 8] <= wword_c[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (1, 0 and 3 wait states)
// driven from one initial block; responses are checked against a reference model.
module tb_dmem_responder;

   typedef struct {
      int          inst;
      logic [31:0] rdata;
      logic        err;
      logic [15:0] wcnt;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst        [3];
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic        resp_valid [3];
   logic [31:0] readdata   [3];
   logic        addr_err   [3];
   logic [15:0] wr_count   [3];
   logic        memwrite;
   logic [31:0] dataadr, writedata;
   logic [1:0]  size;
   logic        sign_ext;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   exp_t        sbq [$];
   exp_t        me;
   logic [31:0] mdl [3][64];
   int          mdl_cnt [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .size(size),
      .sign_ext(sign_ext), .resp_valid(resp_valid[0]), .readdata(readdata[0]),
      .addr_err(addr_err[0]), .wr_count(wr_count[0]));

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .size(size),
      .sign_ext(sign_ext), .resp_valid(resp_valid[1]), .readdata(readdata[1]),
      .addr_err(addr_err[1]), .wr_count(wr_count[1]));

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .size(size),
      .sign_ext(sign_ext), .resp_valid(resp_valid[2]), .readdata(readdata[2]),
      .addr_err(addr_err[2]), .wr_count(wr_count[2]));

   function automatic int wait_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : 3;
   endfunction

   // Reference model: compute the response for a request accepted at the next edge.
   task automatic expect_req(input int i, input logic we, input logic [31:0] adr,
                             input logic [31:0] wd, input logic [1:0] sz, input logic sx);
      exp_t        e;
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      logic        bad;
      bad = (sz == 2'b11) || (sz == 2'b01 && adr[0]) ||
            (sz == 2'b10 && adr[1:0] != 2'b00) || (adr[31:2] >= 30'd64);
      e.rdata = 32'd0;
      e.err   = bad;
      if (!bad) begin
         w = mdl[i][adr[7:2]];
         b = w[8*adr[1:0] +: 8];
         h = w[16*adr[1] +: 16];
         if (we) begin
            case (sz)
               2'b00:   w[8*adr[1:0] +: 8] = wd[7:0];
               2'b01:   w[16*adr[1] +: 16] = wd[15:0];
               default: w = wd;
            endcase
            mdl[i][adr[7:2]] = w;
            if (mdl_cnt[i] < 65535) mdl_cnt[i]++;
         end else begin
            case (sz)
               2'b00:   e.rdata = sx ? {{24{b[7]}}, b} : {24'h0, b};
               2'b01:   e.rdata = sx ? {{16{h[15]}}, h} : {16'h0, h};
               default: e.rdata = w;
            endcase
         end
      end
      e.inst = i;
      e.wcnt = 16'(mdl_cnt[i]);
      e.acc  = cyc + 1;
      sbq.push_back(e);
   endtask

   // Response monitor: pop the scoreboard on every resp_valid.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (resp_valid[i] === 1'b1) begin
            if (sbq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_resp inst=%0d cyc=%0d", i, cyc);
            end else begin
               me = sbq.pop_front();
               n_tests++;
               if (me.inst !== i) begin n_fail++; $display("FAIL resp_inst got=%0d want=%0d", i, me.inst); end
               n_tests++;
               if (readdata[i] !== me.rdata) begin n_fail++; $display("FAIL readdata inst=%0d got=%h want=%h", i, readdata[i], me.rdata); end
               n_tests++;
               if (addr_err[i] !== me.err) begin n_fail++; $display("FAIL addr_err inst=%0d got=%b want=%b", i, addr_err[i], me.err); end
               n_tests++;
               if (wr_count[i] !== me.wcnt) begin n_fail++; $display("FAIL wr_count inst=%0d got=%0d want=%0d", i, wr_count[i], me.wcnt); end
               n_tests++;
               if (cyc - me.acc !== wait_of(i) + 1) begin n_fail++; $display("FAIL latency inst=%0d got=%0d want=%0d", i, cyc - me.acc, wait_of(i) + 1); end
            end
         end
      end
   end

   task automatic wait_drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 30) begin @(negedge clk); n++; end
      if (sbq.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL resp_timeout pending=%0d", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic wait_ready(input int i, output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready[i] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      ok = (req_ready[i] === 1'b1);
      if (!ok) begin n_tests++; n_fail++; $display("FAIL ready_timeout inst=%0d", i); end
   endtask

   task automatic do_req(input int i, input logic we, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [1:0] sz, input logic sx);
      bit ok;
      wait_ready(i, ok);
      if (ok) begin
         memwrite = we; dataadr = adr; writedata = wd; size = sz; sign_ext = sx;
         req_valid[i] = 1'b1;
         expect_req(i, we, adr, wd, sz, sx);
         @(negedge clk);
         req_valid[i] = 1'b0;
         wait_drain();
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin rst[i] = 1'b1; req_valid[i] = 1'b0; mdl_cnt[i] = 0; end
      memwrite = 1'b0; dataadr = '0; writedata = '0; size = 2'b10; sign_ext = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (req_ready[i] !== 1'b0) begin n_fail++; $display("FAIL rst_ready inst=%0d got=%b want=0", i, req_ready[i]); end
         n_tests++;
         if (resp_valid[i] !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid inst=%0d got=%b want=0", i, resp_valid[i]); end
         n_tests++;
         if (readdata[i] !== 32'd0) begin n_fail++; $display("FAIL rst_readdata inst=%0d got=%h want=0", i, readdata[i]); end
         n_tests++;
         if (addr_err[i] !== 1'b0) begin n_fail++; $display("FAIL rst_addr_err inst=%0d got=%b want=0", i, addr_err[i]); end
         n_tests++;
         if (wr_count[i] !== 16'd0) begin n_fail++; $display("FAIL rst_wr_count inst=%0d got=%0d want=0", i, wr_count[i]); end
         rst[i] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (req_ready[i] !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready inst=%0d got=%b want=1", i, req_ready[i]); end
      end
   endtask

   task automatic test_word_round_trip();
      do_req(0, 1'b1, 32'd84, 32'h0000_0007, 2'b10, 1'b0);
      do_req(0, 1'b0, 32'd84, 32'h0, 2'b10, 1'b0);
      n_tests++;
      if (wr_count[0] !== 16'd1) begin n_fail++; $display("FAIL round_trip_count got=%0d want=1", wr_count[0]); end
   endtask

   task automatic test_byte_merge();
      do_req(0, 1'b1, 32'h50, 32'h1122_3344, 2'b10, 1'b0);
      do_req(0, 1'b1, 32'h51, 32'h1234_56AB, 2'b00, 1'b0);
      do_req(0, 1'b0, 32'h50, 32'h0, 2'b10, 1'b0);
      do_req(0, 1'b0, 32'h51, 32'h0, 2'b00, 1'b1);
      do_req(0, 1'b0, 32'h51, 32'h0, 2'b00, 1'b0);
      do_req(0, 1'b1, 32'h5E, 32'h0000_8001, 2'b01, 1'b0);
      do_req(0, 1'b0, 32'h5E, 32'h0, 2'b01, 1'b1);
      do_req(0, 1'b0, 32'h5C, 32'h0, 2'b10, 1'b0);
   endtask

   task automatic test_errors();
      int wc;
      wc = mdl_cnt[0];
      do_req(0, 1'b1, 32'h52,  32'hFFFF_FFFF, 2'b10, 1'b0);
      do_req(0, 1'b0, 32'h51,  32'h0,         2'b01, 1'b0);
      do_req(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 2'b10, 1'b0);
      do_req(0, 1'b1, 32'h50,  32'hFFFF_FFFF, 2'b11, 1'b0);
      do_req(0, 1'b0, 32'h50,  32'h0,         2'b10, 1'b0);
      n_tests++;
      if (wr_count[0] !== 16'(wc)) begin n_fail++; $display("FAIL err_count got=%0d want=%0d", wr_count[0], wc); end
   endtask

   // Assert rst on the edge after acceptance (WAIT for 3 wait states, ACCESS for 0).
   task automatic test_reset_drop(input int i, input logic [31:0] adr);
      bit ok;
      int seen;
      do_req(i, 1'b1, adr, 32'h1234_5678 ^ 32'(i), 2'b10, 1'b0);
      wait_ready(i, ok);
      if (ok) begin
         memwrite = 1'b1; dataadr = adr; writedata = 32'hDEAD_BEEF; size = 2'b10; sign_ext = 1'b0;
         req_valid[i] = 1'b1;
         @(negedge clk);
         req_valid[i] = 1'b0;
         rst[i] = 1'b1;
         @(negedge clk);
         seen = (resp_valid[i] === 1'b1) ? 1 : 0;
         n_tests++;
         if (req_ready[i] !== 1'b0) begin n_fail++; $display("FAIL drop_ready_in_rst inst=%0d got=%b want=0", i, req_ready[i]); end
         rst[i] = 1'b0;
         mdl_cnt[i] = 0;
         @(negedge clk);
         n_tests++;
         if (req_ready[i] !== 1'b1) begin n_fail++; $display("FAIL drop_ready_after inst=%0d got=%b want=1", i, req_ready[i]); end
         repeat (8) begin
            @(negedge clk);
            if (resp_valid[i] === 1'b1) seen++;
         end
         n_tests++;
         if (seen !== 0) begin n_fail++; $display("FAIL drop_resp inst=%0d got=%0d want=0", i, seen); end
         n_tests++;
         if (wr_count[i] !== 16'd0) begin n_fail++; $display("FAIL drop_count inst=%0d got=%0d want=0", i, wr_count[i]); end
      end
      do_req(i, 1'b0, adr, 32'h0, 2'b10, 1'b0);
   endtask

   task automatic test_handshake();
      int n_acc, last_acc;
      for (int w = 32; w < 56; w++) do_req(0, 1'b1, 32'(4 * w), 32'h0, 2'b10, 1'b0);
      n_acc = 0;
      last_acc = -1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         memwrite = 1'b1; dataadr = 32'(32'h80 + 4 * c); writedata = 32'(32'hA000 + c);
         size = 2'b10; sign_ext = 1'b0; req_valid[0] = 1'b1;
         if (req_ready[0] === 1'b1) begin
            expect_req(0, 1'b1, dataadr, writedata, 2'b10, 1'b0);
            if (last_acc >= 0) begin
               n_tests++;
               if (cyc + 1 - last_acc !== 4) begin n_fail++; $display("FAIL accept_spacing got=%0d want=4", cyc + 1 - last_acc); end
            end
            last_acc = cyc + 1;
            n_acc++;
         end
      end
      @(negedge clk);
      req_valid[0] = 1'b0;
      wait_drain();
      n_tests++;
      if (n_acc !== 6) begin n_fail++; $display("FAIL accept_count got=%0d want=6", n_acc); end
      for (int w = 32; w < 56; w++) do_req(0, 1'b0, 32'(4 * w), 32'h0, 2'b10, 1'b0);
   endtask

   task automatic test_zero_wait();
      do_req(1, 1'b1, 32'h20, 32'hCAFE_F00D, 2'b10, 1'b0);
      do_req(1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
      do_req(1, 1'b1, 32'h23, 32'h0000_0080, 2'b00, 1'b0);
      do_req(1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
      do_req(1, 1'b0, 32'h23, 32'h0, 2'b00, 1'b1);
   endtask

   initial begin
      test_reset();
      test_word_round_trip();
      test_byte_merge();
      test_errors();
      test_reset_drop(2, 32'h10);
      test_reset_drop(1, 32'h14);
      test_handshake();
      test_zero_wait();
      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
